// File: rtl/fetch_queue_frontend.sv
// rtl/fetch_queue_frontend.sv - instruction fetch frontend with static prediction and a DEPTH-entry fetch queue
//
// Fetches one word per cycle from a combinational instruction memory, picks the
// next fetch address with a static branch/jump predictor and queues
// {pc, instr, pred} for decode. A redirect from execute flushes and restarts.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   iaddr, ireq         fetch address (fetch PC) and fetch strobe
//   idata               instruction word at iaddr, same cycle
//   redirect,
//   redirect_pc         flush request and restart address from execute
//   out_valid,
//   out_ready           head-of-queue handshake towards decode
//   out_pc, out_instr,
//   out_pred            head entry fields (all zero while the queue is empty)
module fetch_queue_frontend #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter bit          PREDICT  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] iaddr,
    output logic        ireq,
    input  logic [31:0] idata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [31:0] out_pred
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    logic [31:0]   fpc_q, fpc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic [31:0] pc_mem_q    [DEPTH];
    logic [31:0] pc_mem_d    [DEPTH];
    logic [31:0] instr_mem_q [DEPTH];
    logic [31:0] instr_mem_d [DEPTH];
    logic [31:0] pred_mem_q  [DEPTH];
    logic [31:0] pred_mem_d  [DEPTH];

    logic        push;
    logic        pop;
    logic [5:0]  opcode;
    logic [31:0] seq_pc;
    logic [31:0] br_off;
    logic [31:0] pred_pc;

    // Static predictor: backward conditional branches taken, jumps always taken.
    always_comb begin
        opcode  = idata[31:26];
        seq_pc  = fpc_q + 32'd4;
        br_off  = {{14{idata[15]}}, idata[15:0], 2'b00};
        pred_pc = seq_pc;
        if (PREDICT) begin
            if ((opcode == OP_BEQ || opcode == OP_BNE) && idata[15]) begin
                pred_pc = seq_pc + br_off;
            end else if (opcode == OP_J || opcode == OP_JAL) begin
                pred_pc = {seq_pc[31:28], idata[25:0], 2'b00};
            end
        end
    end

    assign out_valid = (count_q != '0);
    // A redirect discards the head, so decode's accept is ignored that cycle.
    assign pop       = out_valid & out_ready & ~redirect;
    // When full, a same-cycle pop frees the slot being written.
    assign ireq      = ~reset & ~redirect & ((count_q != FULL_CNT) | pop);
    assign push      = ireq;
    assign iaddr     = fpc_q;

    always_comb begin
        fpc_d    = fpc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            fpc_d    = redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                fpc_d    = pred_pc;
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fpc_q    <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            fpc_q    <= fpc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_comb begin
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        pred_mem_d  = pred_mem_q;
        if (push) begin
            pc_mem_d[wr_ptr_q]    = fpc_q;
            instr_mem_d[wr_ptr_q] = idata;
            pred_mem_d[wr_ptr_q]  = pred_pc;
        end
    end

    always_ff @(posedge clk) begin
        pc_mem_q    <= pc_mem_d;
        instr_mem_q <= instr_mem_d;
        pred_mem_q  <= pred_mem_d;
    end

    assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : 32'd0;
    assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : 32'd0;
    assign out_pred  = out_valid ? pred_mem_q[rd_ptr_q]  : 32'd0;

endmodule

// File: tb/tb_fetch_queue_frontend.sv
// tb/tb_fetch_queue_frontend.sv - self-checking bench for fetch_queue_frontend
module tb_fetch_queue_frontend;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0020;
    localparam int          NV       = 16;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pred;
    } ent_t;

    typedef struct {
        bit          rst;
        bit          ordy;
        bit          ev;
        bit          ei;
        logic [31:0] ea;
        logic [31:0] ep;
        logic [31:0] epr;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        redirect;
    logic        out_ready;
    logic [31:0] redirect_pc;

    // Index 0: PREDICT=1 instance, index 1: PREDICT=0 instance.
    logic [31:0] iaddr_w     [2];
    logic [31:0] idata_w     [2];
    logic [31:0] out_pc_w    [2];
    logic [31:0] out_instr_w [2];
    logic [31:0] out_pred_w  [2];
    logic        ireq_w      [2];
    logic        out_valid_w [2];

    bit          rand_mode;
    logic [31:0] rseed;
    logic [31:0] patch_addr;
    logic [31:0] patch_word;

    int   n_vec;
    int   n_err;
    ent_t mq   [2][$];
    logic [31:0] mfpc [2];
    vec_t vt   [NV];

    fetch_queue_frontend #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .PREDICT(1'b1)) dut (
        .clk(clk), .reset(reset), .iaddr(iaddr_w[0]), .ireq(ireq_w[0]), .idata(idata_w[0]),
        .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid_w[0]),
        .out_ready(out_ready), .out_pc(out_pc_w[0]), .out_instr(out_instr_w[0]),
        .out_pred(out_pred_w[0])
    );

    fetch_queue_frontend #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .PREDICT(1'b0)) dut_np (
        .clk(clk), .reset(reset), .iaddr(iaddr_w[1]), .ireq(ireq_w[1]), .idata(idata_w[1]),
        .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid_w[1]),
        .out_ready(out_ready), .out_pc(out_pc_w[1]), .out_instr(out_instr_w[1]),
        .out_pred(out_pred_w[1])
    );

    // Instruction memory: one patchable word, else NOP or an address-hashed mix
    // of ALU ops, branches and jumps.
    function automatic logic [31:0] mem_rd(input logic [31:0] a, input bit rm, input logic [31:0] seed,
                                           input logic [31:0] pa, input logic [31:0] pw);
        logic [31:0] h;
        if (a == pa) return pw;
        if (!rm) return NOP;
        h = (a ^ seed) * 32'h9E37_79B1;
        h = h ^ (h >> 15);
        case (h[31:29])
            3'd3:    return {6'd4, h[25:0]};
            3'd4:    return {6'd5, h[25:0]};
            3'd5:    return {6'd2, h[25:0]};
            3'd6:    return {6'd3, h[25:0]};
            3'd7:    return {6'd8, h[25:0]};
            default: return {6'd0, h[25:0]};
        endcase
    endfunction

    assign idata_w[0] = mem_rd(iaddr_w[0], rand_mode, rseed, patch_addr, patch_word);
    assign idata_w[1] = mem_rd(iaddr_w[1], rand_mode, rseed, patch_addr, patch_word);

    function automatic logic [31:0] ref_pred(input logic [31:0] pc, input logic [31:0] w, input bit pr);
        logic [31:0] seq;
        logic [5:0]  op;
        logic [15:0] imm;
        logic [25:0] tgt;
        int          off;
        seq = pc + 32'd4;
        op  = w[31:26];
        imm = w[15:0];
        tgt = w[25:0];
        if (pr && (op == 6'd4 || op == 6'd5) && imm[15]) begin
            off = int'(signed'(imm));
            return seq + 32'(off * 4);
        end
        if (pr && (op == 6'd2 || op == 6'd3)) return (seq & 32'hF000_0000) | (32'(tgt) * 32'd4);
        return seq;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compares both instances against the queue model, then advances the model.
    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            int          n;
            bit          ev;
            bit          pop;
            bit          ei;
            ent_t        head;
            logic [31:0] w;
            logic [31:0] p;
            n  = mq[m].size();
            ev = (n != 0);
            pop = ev && out_ready && !redirect;
            ei  = !reset && !redirect && (n < DEPTH || pop);
            head.pc = 32'd0; head.instr = 32'd0; head.pred = 32'd0;
            if (ev) head = mq[m][0];
            chk($sformatf("model%0d.out_valid", m), 32'(out_valid_w[m]), 32'(ev));
            chk($sformatf("model%0d.ireq", m), 32'(ireq_w[m]), 32'(ei));
            chk($sformatf("model%0d.iaddr", m), iaddr_w[m], mfpc[m]);
            chk($sformatf("model%0d.out_pc", m), out_pc_w[m], head.pc);
            chk($sformatf("model%0d.out_instr", m), out_instr_w[m], head.instr);
            chk($sformatf("model%0d.out_pred", m), out_pred_w[m], head.pred);
            if (reset) begin
                mq[m].delete();
                mfpc[m] = RESET_PC;
            end else if (redirect) begin
                mq[m].delete();
                mfpc[m] = redirect_pc;
            end else begin
                if (pop) void'(mq[m].pop_front());
                if (ei) begin
                    w = mem_rd(mfpc[m], rand_mode, rseed, patch_addr, patch_word);
                    p = ref_pred(mfpc[m], w, m == 0);
                    mq[m].push_back('{pc: mfpc[m], instr: w, pred: p});
                    mfpc[m] = p;
                end
            end
        end
    endtask

    task automatic apply(input bit rst, input bit rd, input logic [31:0] rpc, input bit ordy);
        reset       = rst;
        redirect    = rd;
        redirect_pc = rpc;
        out_ready   = ordy;
        @(negedge clk);
        model_step();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Redirect to addr holding word; check the queued entry and the next fetch address.
    task automatic probe(input string name, input logic [31:0] addr, input logic [31:0] word,
                         input logic [31:0] e1, input logic [31:0] e0);
        patch_addr = addr;
        patch_word = word;
        apply(1'b0, 1'b1, addr, 1'b1);
        chk({name, ".ireq_on_redirect"}, 32'(ireq_w[0]), 32'd0);
        tick();
        apply(1'b0, 1'b0, 32'd0, 1'b1);
        chk({name, ".valid_after_redirect"}, 32'(out_valid_w[0]), 32'd0);
        chk({name, ".iaddr_after_redirect"}, iaddr_w[0], addr);
        chk({name, ".ireq_after_redirect"}, 32'(ireq_w[0]), 32'd1);
        tick();
        apply(1'b0, 1'b0, 32'd0, 1'b1);
        chk({name, ".out_pc"}, out_pc_w[0], addr);
        chk({name, ".out_pred_p1"}, out_pred_w[0], e1);
        chk({name, ".out_pred_p0"}, out_pred_w[1], e0);
        chk({name, ".iaddr_p1"}, iaddr_w[0], e1);
        chk({name, ".iaddr_p0"}, iaddr_w[1], e0);
        tick();
        patch_addr = 32'hFFFF_FFFF;
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rand_mode   = 1'b0;
        rseed       = 32'd0;
        patch_addr  = 32'hFFFF_FFFF;
        patch_word  = NOP;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        out_ready   = 1'b0;
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            mq[m].delete();
            mfpc[m] = RESET_PC;
        end

        // Reset, then 10 cycles of back-pressure, then drain with concurrent fetch.
        vt[0]  = '{1, 0, 0, 0, 32'd0,  32'd0,  32'd0};
        vt[1]  = '{0, 0, 0, 1, 32'd0,  32'd0,  32'd0};
        vt[2]  = '{0, 0, 1, 1, 32'd4,  32'd0,  32'd4};
        vt[3]  = '{0, 0, 1, 1, 32'd8,  32'd0,  32'd4};
        vt[4]  = '{0, 0, 1, 1, 32'd12, 32'd0,  32'd4};
        for (int i = 5; i <= 10; i++) vt[i] = '{0, 0, 1, 0, 32'd16, 32'd0, 32'd4};
        vt[11] = '{0, 1, 1, 1, 32'd16, 32'd0,  32'd4};
        vt[12] = '{0, 1, 1, 1, 32'd20, 32'd4,  32'd8};
        vt[13] = '{0, 1, 1, 1, 32'd24, 32'd8,  32'd12};
        vt[14] = '{0, 1, 1, 1, 32'd28, 32'd12, 32'd16};
        vt[15] = '{0, 1, 1, 1, 32'd32, 32'd16, 32'd20};

        for (int i = 0; i < NV; i++) begin
            apply(vt[i].rst, 1'b0, 32'd0, vt[i].ordy);
            chk($sformatf("vec%0d.out_valid", i), 32'(out_valid_w[0]), 32'(vt[i].ev));
            chk($sformatf("vec%0d.ireq", i), 32'(ireq_w[0]), 32'(vt[i].ei));
            chk($sformatf("vec%0d.iaddr", i), iaddr_w[0], vt[i].ea);
            chk($sformatf("vec%0d.out_pc", i), out_pc_w[0], vt[i].ep);
            chk($sformatf("vec%0d.out_pred", i), out_pred_w[0], vt[i].epr);
            tick();
        end

        // beq rs=1 rt=2: backward taken, forward not taken; jump; PC wrap.
        probe("beq_back", 32'h0000_0040, 32'h1022_FFFC, 32'h0000_0034, 32'h0000_0044);
        probe("beq_fwd",  32'h0000_0040, 32'h1022_0004, 32'h0000_0044, 32'h0000_0044);
        probe("j",        32'h1000_0010, 32'h0800_0100, 32'h1000_0400, 32'h1000_0014);
        probe("wrap",     32'hFFFF_FFFC, NOP,           32'h0000_0000, 32'h0000_0000);

        // Redirect while holding 3 entries with decode ready.
        apply(1'b0, 1'b1, 32'h0000_0100, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 32'd0, 1'b0);
            tick();
        end
        apply(1'b0, 1'b1, 32'h0000_0200, 1'b1);
        chk("flush3.head_pc", out_pc_w[0], 32'h0000_0100);
        chk("flush3.ireq", 32'(ireq_w[0]), 32'd0);
        tick();
        apply(1'b0, 1'b0, 32'd0, 1'b1);
        chk("flush3.valid", 32'(out_valid_w[0]), 32'd0);
        chk("flush3.iaddr", iaddr_w[0], 32'h0000_0200);
        chk("flush3.ireq_next", 32'(ireq_w[0]), 32'd1);
        tick();
        apply(1'b0, 1'b0, 32'd0, 1'b1);
        chk("flush3.first_pc", out_pc_w[0], 32'h0000_0200);
        chk("flush3.first_valid", 32'(out_valid_w[0]), 32'd1);
        tick();

        // Reset asserted while the queue is full.
        apply(1'b0, 1'b1, 32'h0000_0300, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b0, 32'd0, 1'b0);
            tick();
        end
        apply(1'b0, 1'b0, 32'd0, 1'b0);
        chk("full.ireq", 32'(ireq_w[0]), 32'd0);
        chk("full.iaddr", iaddr_w[0], 32'h0000_0310);
        tick();
        apply(1'b1, 1'b0, 32'd0, 1'b1);
        tick();
        apply(1'b0, 1'b0, 32'd0, 1'b1);
        chk("rst_full.valid", 32'(out_valid_w[0]), 32'd0);
        chk("rst_full.iaddr", iaddr_w[0], RESET_PC);
        chk("rst_full.ireq", 32'(ireq_w[0]), 32'd1);
        tick();

        // Random traffic against the queue model.
        rand_mode = 1'b1;
        rseed     = $urandom;
        for (int i = 0; i < 1500; i++) begin
            bit          rst;
            bit          rd;
            bit          ordy;
            logic [31:0] rpc;
            rst  = ($urandom_range(0, 63) == 0);
            rd   = ($urandom_range(0, 15) == 0);
            ordy = ($urandom_range(0, 3) != 0);
            rpc  = $urandom;
            rpc  = rpc & 32'hFFFF_FFFC;
            apply(rst, rd, rpc, ordy);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_queue_frontend.md
# fetch_queue_frontend

Parametrised instruction-fetch frontend for the pipelined MIPS core, the successor to the current single-buffer frontend. Fetches one word per cycle from a combinational instruction memory and applies a static branch/jump prediction to select the next fetch address. Fetched words go into a DEPTH-entry FIFO drained by decode through a valid/ready handshake. A redirect from execute flushes the FIFO and restarts fetch. All state updates on the rising edge only.

## Interface
- DEPTH, 4, fetch-queue entries; power of two, ≥ 2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- PREDICT, 1, 1 = static prediction enabled; 0 = always predict pc+4
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- iaddr  out  32  instruction memory address (= fetch PC register fpc)
- ireq  out  1  fetch this cycle; idata is consumed only when ireq=1
- idata  in  32  instruction word at iaddr, valid in the same cycle
- redirect  in  1  misprediction/flush request from execute
- redirect_pc  in  32  restart address, sampled when redirect=1
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_pc  out  32  head PC
- out_instr  out  32  head instruction word
- out_pred  out  32  predicted next PC recorded for the head (execute compares against the resolved PC)

## Operation
- State: fpc[31:0], FIFO storage {pc, instr, pred} × DEPTH, rd/wr pointers (log2 DEPTH bits, wrap mod DEPTH), count (0..DEPTH).
- pop = out_valid & out_ready & !redirect.
- ireq = !reset & !redirect & (count < DEPTH | pop).
- Prediction, computed combinationally from fpc/idata; seq = fpc + 4 (mod 2^32):
  - beq (opcode 6'b000100) / bne (6'b000101), PREDICT=1, idata[15]=1 (backward): pred = seq + (sext(idata[15:0]) << 2).
  - j (6'b000010) / jal (6'b000011), PREDICT=1: pred = {seq[31:28], idata[25:0], 2'b00}.
  - Otherwise: pred = seq. No delay slot is modelled.
- Fetch (ireq=1): push {fpc, idata, pred}; fpc ← pred.
- Redirect (highest priority, below reset): count ← 0, pointers ← 0, fpc ← redirect_pc. Nothing is pushed and nothing is popped. The head presented in that cycle is discarded even if out_ready=1.
- Full, no pop: ireq=0, fpc and FIFO held.
- Full with pop: push and pop in the same cycle; count unchanged.
- Empty: out_valid=0; out_ready is ignored.
- Empty outputs: out_pc, out_instr and out_pred drive 0. Non-empty: they reflect the head entry.
- Reset: fpc ← RESET_PC, count ← 0, pointers ← 0. A reset asserted mid-stream drops all entries, including any simultaneous push, pop or redirect.

## Timing
- Reset values: iaddr=RESET_PC, ireq=0 during reset, out_valid=0, out_pc/out_instr/out_pred=0.
- First cycle after reset deasserts: ireq=1, iaddr=RESET_PC.
- Fetch-to-output latency: 1 cycle. A word fetched in cycle n is at the head in cycle n+1 if the queue was empty.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Redirect in cycle n: out_valid=0 in cycle n+1, iaddr=redirect_pc with ireq=1 in n+1, first redirected entry at the head in n+2.
- Back-pressure: with out_ready=0 continuously, exactly DEPTH words are fetched, then ireq drops. Fetch resumes in the same cycle out_ready rises (full-with-pop rule).
- ireq depends combinationally on out_ready and redirect. idata must not depend combinationally on ireq.

## Test plan
- Reset release, memory returns sequential ALU ops, out_ready=1 → iaddr 0,4,8,…; out_pc follows one cycle later; out_pred = out_pc+4.
- DEPTH=4, out_ready=0 for 10 cycles → exactly 4 fetches (PCs 0,4,8,12), ireq=0 afterward, iaddr held at 16. Then out_ready=1 → pop and fetch in the same cycle; out_pc order 0,4,8,12,16.
- At PC 0x40, beq with imm=16'hFFFC (backward) → out_pred=0x34 and next iaddr=0x34. Same test with imm=16'h0004 (forward) → out_pred=0x44.
- At PC 0x1000_0010, j with target 26'h000_0100 → next iaddr=0x1000_0400. With PREDICT=0 → next iaddr=0x1000_0014.
- Queue holding 3 entries, redirect=1 with redirect_pc=0x200 and out_ready=1 → no pop is counted; next cycle out_valid=0 and iaddr=0x200; following cycle out_pc=0x200.
- fpc=0xFFFF_FFFC with a non-branch instruction → next iaddr wraps to 0x0. Reset asserted while full → next cycle out_valid=0 and iaddr=RESET_PC.
